branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Parametrised dynamic branch predictor and resolver for the RISC-V pipeline. The IF stage reads a taken/not-taken guess from a table of 2-bit saturating counters indexed by PC. At EX, the branch outcome is resolved from BrEq/BrLt using the existing `bresult_sel` encoding. The resolver raises `mispredict` for the same-cycle flush and trains the table on the next clock edge. Saturating branch and miss statistics counters are kept for performance measurement.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `BHT_DEPTH`, 64, number of counters; power of two, ≥ 4; `IDX_W = log2(BHT_DEPTH)`.
- `GHR_W`, 6, global history width; must be ≤ `IDX_W`.
- `STAT_W`, 32, width of the statistics counters.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_pc`  in  XLEN  fetch PC to predict.
- `pred_taken`  out  1  prediction for `if_pc`, combinational.
- `pred_ghr`  out  GHR_W  history snapshot used for this lookup; carried down the pipe.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_pc`  in  XLEN  PC of the EX instruction.
- `ex_ghr`  in  GHR_W  `pred_ghr` value captured when the EX instruction was fetched.
- `ex_pred_taken`  in  1  `pred_taken` value captured when the EX instruction was fetched.
- `bresult_sel`  in  3  bit0 = conditional branch; [2:1]: 00 BEQ, 01 BNE, 10 BLT/BLTU, 11 BGE/BGEU.
- `BrEq`, `BrLt`  in  1  comparator outputs.
- `ex_taken`  out  1  resolved outcome, combinational.
- `mispredict`  out  1  resolved outcome ≠ `ex_pred_taken`, combinational.
- `br_count`  out  STAT_W  resolved branches since reset.
- `miss_count`  out  STAT_W  mispredicted branches since reset.

## Operation
- Resolve event: `res = ex_valid & bresult_sel[0]`.
- Outcome `ex_taken` is selected by `bresult_sel[2:1]`:
  - 00: `BrEq`.
  - 01: `!BrEq`.
  - 10: `BrLt`.
  - 11: `!BrLt`.
- `ex_taken` is 0 when `res` is 0.
- `mispredict = res & (ex_taken != ex_pred_taken)`. It is 0 otherwise, including for non-branch instructions and while `ex_valid` is 0.
- Lookup index is `if_pc[IDX_W+1:2]`. Update index is `ex_pc[IDX_W+1:2]`. PC bits [1:0] are ignored.
- `pred_taken` is the MSB of the counter at the lookup index.
- Counter states:
  - 00 strongly not-taken.
  - 01 weakly not-taken.
  - 10 weakly taken.
  - 11 strongly taken.
- Training on `res`: increment if `ex_taken`, else decrement. Saturate at 11 and 00.
- A table entry is written only on `res`.
- The same index looked up and updated in the same cycle: lookup returns the pre-update value. There is no bypass.
- Statistics:
  - `br_count` increments on `res`.
  - `miss_count` increments on `mispredict`.
  - Both saturate at all-ones and never wrap.
- `ex_pred_taken` = 1 on a non-branch has no effect.

## Timing
- Lookup and resolution are combinational, with zero latency.
- Table, GHR and statistics update on the rising `clk` edge after `res`. The updated value is visible to a lookup from the next cycle.
- Asynchronous reset (`rst_n` = 0), effective immediately, including mid-operation:
  - All counters reset to 01, so `pred_taken` = 0 for every PC.
  - GHR resets to 0, so `pred_ghr` = 0.
  - `br_count` and `miss_count` reset to 0.
- `ex_taken` and `mispredict` follow their inputs during reset.
- Reset release is synchronous to the design's reset synchroniser. No update occurs on the edge where `rst_n` is low.

## Configuration
- Macro `BHT_GSHARE_EN`.
- Defined:
  - A GHR_W-bit global history register shifts left and takes in `ex_taken` on each `res`.
  - Lookup index = `if_pc[IDX_W+1:2] ^ {0, ghr}`.
  - Update index = `ex_pc[IDX_W+1:2] ^ {0, ex_ghr}`.
  - `pred_ghr` = current GHR.
- Undefined:
  - No GHR exists.
  - `pred_ghr` is tied to 0 and `ex_ghr` is ignored.
  - Indexing is PC only.

## Test plan
- Reset, then look up any PC → `pred_taken` = 0; `br_count` = `miss_count` = 0.
- BEQ at PC 0x100, BrEq = 1, `ex_pred_taken` = 0 → `ex_taken` = 1, `mispredict` = 1. Next cycle, lookup of 0x100 → `pred_taken` = 1; counts 1/1.
- Four taken resolutions at 0x100, then two not-taken → counter walks 01→10→11→11→11→10→01. Lookup gives 1 after the fifth resolution and 0 after the sixth.
- For each of the four `bresult_sel[2:1]` codes, all four BrEq/BrLt combinations → `ex_taken` matches the rule above. `bresult_sel[0]` = 0 → `ex_taken` = `mispredict` = 0, with no table or count change.
- Lookup and update of index 5 in the same cycle → lookup returns the old counter. PC 0x114 and PC 0x114 + 4·BHT_DEPTH alias to the same entry.
- Preload `miss_count` to all-ones (STAT_W = 4 build) plus one more mispredict → stays 0xF. Assert `rst_n` mid-run → all outputs reset immediately. With `BHT_GSHARE_EN`: after taken, taken, the GHR is 0b11 and lookup of 0x100 reads index 0 ^ 3 = 3.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// Bimodal/gshare branch predictor: 2-bit saturating counter table, EX-stage resolver, saturating stats.
// Optional gshare indexing via `BHT_GSHARE_EN (default build: PC-only indexing, no GHR).
module branch_predictor_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int GHR_W     = 6,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [GHR_W-1:0]  ex_ghr,
  input  logic              ex_pred_taken,
  input  logic [2:0]        bresult_sel,
  input  logic              BrEq,
  input  logic              BrLt,
  output logic              ex_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        r_bht [BHT_DEPTH];
  logic [STAT_W-1:0] r_br_count;
  logic [STAT_W-1:0] r_miss_count;

  logic              w_res;
  logic              w_taken;
  logic [IDX_W-1:0]  w_lkp_idx;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [1:0]        w_upd_cur;
  logic [1:0]        w_upd_nxt;
  logic              w_unused_ok;

  assign w_res = ex_valid & bresult_sel[0];

  always_comb begin
    w_taken = 1'b0;
    case (bresult_sel[2:1])
      2'b00: w_taken = BrEq;
      2'b01: w_taken = ~BrEq;
      2'b10: w_taken = BrLt;
      2'b11: w_taken = ~BrLt;
      default: w_taken = 1'b0;
    endcase
  end

  assign ex_taken   = w_res & w_taken;
  assign mispredict = w_res & (w_taken != ex_pred_taken);

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  assign w_lkp_idx = if_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_upd_idx = ex_pc[IDX_W+1:2] ^ IDX_W'(ex_ghr);
  assign pred_ghr  = r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_res) begin
      r_ghr <= GHR_W'({r_ghr, w_taken});
    end
  end
`else
  assign w_lkp_idx = if_pc[IDX_W+1:2];
  assign w_upd_idx = ex_pc[IDX_W+1:2];
  assign pred_ghr  = '0;
`endif

  // Only the index field of each PC is meaningful; ex_ghr is dead in the PC-only build.
  assign w_unused_ok = ^{if_pc, ex_pc, ex_ghr};

  // Lookup reads the registered table directly, so a same-cycle update is not bypassed.
  assign pred_taken = r_bht[w_lkp_idx][1];

  assign w_upd_cur = r_bht[w_upd_idx];

  always_comb begin
    w_upd_nxt = w_upd_cur;
    if (w_taken) begin
      if (w_upd_cur != 2'b11) w_upd_nxt = w_upd_cur + 2'd1;
    end else begin
      if (w_upd_cur != 2'b00) w_upd_nxt = w_upd_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (w_res) begin
      r_bht[w_upd_idx] <= w_upd_nxt;
      if (r_br_count != '1) r_br_count <= r_br_count + STAT_W'(1);
      if (mispredict && (r_miss_count != '1)) r_miss_count <= r_miss_count + STAT_W'(1);
    end
  end

  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht, built with STAT_W = 4 so statistics saturation is reachable.
module tb_branch_predictor_bht;
  localparam int XLEN = 32;
  localparam int GHR_W = 6;
  localparam int STAT_W = 4;

  logic              clk;
  logic              rst_n;
  logic [XLEN-1:0]   if_pc;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_ghr;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [GHR_W-1:0]  ex_ghr;
  logic              ex_pred_taken;
  logic [2:0]        bresult_sel;
  logic              BrEq;
  logic              BrLt;
  logic              ex_taken;
  logic              mispredict;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] miss_count;

  int n_chk;
  int n_pass;
  int exp_br;
  int exp_miss;

  branch_predictor_bht #(
    .XLEN(XLEN), .BHT_DEPTH(64), .GHR_W(GHR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ghr(ex_ghr), .ex_pred_taken(ex_pred_taken),
    .bresult_sel(bresult_sel), .BrEq(BrEq), .BrLt(BrLt), .ex_taken(ex_taken),
    .mispredict(mispredict), .br_count(br_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    if_pc = pc;
    #1;
    check(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // Drives one EX instruction for one cycle; counts are tracked here with saturation at 15.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic [2:0] sel,
                         input logic eq, input logic lt, input logic pred,
                         input logic exp_t, input logic exp_m);
    ex_valid = 1'b1; ex_pc = pc; bresult_sel = sel; BrEq = eq; BrLt = lt; ex_pred_taken = pred;
    #1;
    check({tag, "_taken"}, {31'd0, ex_taken}, {31'd0, exp_t});
    check({tag, "_miss"}, {31'd0, mispredict}, {31'd0, exp_m});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_pred_taken = 1'b0;
    if (sel[0]) begin
      if (exp_br < 15) exp_br++;
      if (exp_m && exp_miss < 15) exp_miss++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_br"}, {28'd0, br_count}, exp_br);
    check({tag, "_miss_cnt"}, {28'd0, miss_count}, exp_miss);
  endtask

  logic [3:0] taken_tab [4];
  logic [3:0] row;

  initial begin
    n_chk = 0; n_pass = 0; exp_br = 0; exp_miss = 0;
    taken_tab[0] = 4'b1100;  // BEQ: taken when BrEq (combo bit1)
    taken_tab[1] = 4'b0011;  // BNE
    taken_tab[2] = 4'b1010;  // BLT: taken when BrLt (combo bit0)
    taken_tab[3] = 4'b0101;  // BGE
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_ghr = '0;
    ex_pred_taken = 1'b0; bresult_sel = 3'b000; BrEq = 1'b0; BrLt = 1'b0;
    #12;
    lookup("rst_pred_100", 32'h100, 1'b0);
    lookup("rst_pred_7fc", 32'h7fc, 1'b0);
    check_counts("rst");
    check("rst_ghr", {26'd0, pred_ghr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BHT_GSHARE_EN
    ex_ghr = 6'd0;
    resolve("gs_t1", 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("gs_ghr1", {26'd0, pred_ghr}, 32'd1);
    ex_ghr = 6'd1;
    resolve("gs_t2", 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("gs_ghr2", {26'd0, pred_ghr}, 32'd3);
    lookup("gs_idx3", 32'h100, 1'b0);
    lookup("gs_idx0", 32'h10c, 1'b1);
    ex_ghr = 6'd0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    exp_br = 0; exp_miss = 0;
    check("gs_rst_ghr", {26'd0, pred_ghr}, 32'd0);
    @(posedge clk); #1;
`endif

    resolve("beq_100", 32'h100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    lookup("pred_100_after", 32'h100, 1'b1);
    check_counts("first");

    // Fresh entry at index 2 walks 01->10->11->11->11->10->01
    resolve("walk1", 32'h208, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    lookup("walk1_pred", 32'h208, 1'b1);
    resolve("walk2", 32'h208, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    resolve("walk3", 32'h208, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    resolve("walk4", 32'h208, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    lookup("walk4_pred", 32'h208, 1'b1);
    resolve("walk5", 32'h208, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    lookup("walk5_pred", 32'h208, 1'b1);
    resolve("walk6", 32'h208, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    lookup("walk6_pred", 32'h208, 1'b0);
    check_counts("walk");
    check("walk_br_hand", {28'd0, br_count}, 32'd7);
    check("walk_miss_hand", {28'd0, miss_count}, 32'd4);

    for (int code = 0; code < 4; code++) begin
      row = taken_tab[code];
      for (int c = 0; c < 4; c++) begin
        resolve($sformatf("sel%0d_c%0d", code, c), 32'h3f0, {code[1:0], 1'b1},
                c[1], c[0], 1'b0, row[c], row[c]);
      end
    end
    check("sel_br_sat", {28'd0, br_count}, 32'd15);
    check("sel_miss_hand", {28'd0, miss_count}, 32'd12);

    resolve("nonbr", 32'h100, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ex_valid = 1'b0; bresult_sel = 3'b001; BrEq = 1'b1; ex_pred_taken = 1'b0;
    #1;
    check("novalid_taken", {31'd0, ex_taken}, 32'd0);
    check("novalid_miss", {31'd0, mispredict}, 32'd0);
    @(posedge clk); #1;
    check_counts("nonbr");
    lookup("nonbr_pred_100", 32'h100, 1'b1);

    // Same-cycle lookup of index 5 while its alias 0x114+4*64 is updated
    if_pc = 32'h114;
    ex_valid = 1'b1; ex_pc = 32'h214; bresult_sel = 3'b001; BrEq = 1'b1; BrLt = 1'b0;
    ex_pred_taken = 1'b0;
    #1;
    check("same_cyc_old", {31'd0, pred_taken}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    exp_miss++;
    lookup("alias_new", 32'h114, 1'b1);
    check("miss_13", {28'd0, miss_count}, 32'd13);

    resolve("sat_a", 32'h010, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    resolve("sat_b", 32'h010, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("miss_15", {28'd0, miss_count}, 32'd15);
    resolve("sat_c", 32'h010, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("miss_hold", {28'd0, miss_count}, 32'd15);
    check("ghr_tied", {26'd0, pred_ghr}, 32'd0);

    #3;
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_pc = 32'h100; bresult_sel = 3'b001; BrEq = 1'b1; ex_pred_taken = 1'b0;
    exp_br = 0; exp_miss = 0;
    #1;
    check_counts("midrst");
    lookup("midrst_pred_114", 32'h114, 1'b0);
    check("midrst_taken", {31'd0, ex_taken}, 32'd1);
    check("midrst_miss", {31'd0, mispredict}, 32'd1);
    @(posedge clk); #1;
    check_counts("rst_edge");
    lookup("rst_edge_pred_100", 32'h100, 1'b0);
    ex_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lookup("post_rst_100", 32'h100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
